// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU word type, muldiv opcodes and muldiv FSM states
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Two's-complement magnitude when neg is set, otherwise pass-through.
  function automatic word_t mag(input word_t v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 32-cycle multiply/divide unit owning HI/LO
module muldiv_unit
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       start,
  input  muldiv_op_t op,
  input  word_t      rs_dat,
  input  word_t      rt_dat,
  input  logic       flush,
  output logic       busy,
  output logic       done,
  output word_t      hi,
  output word_t      lo
);

  md_state_t   state_q;
  logic [4:0]  cnt_q;
  logic [63:0] acc_q;
  word_t       b_q;
  logic        is_div_q;
  logic        neg_q;
  logic        neg_rem_q;
  logic        div0_q;
  word_t       hi_q;
  word_t       lo_q;
  logic        done_q;

  logic [32:0] opa;
  logic [32:0] opb;
  logic [32:0] opb_x;
  logic [33:0] sum;
  logic [63:0] acc_d;
  logic [63:0] prod;
  word_t       res_hi;
  word_t       res_lo;

  logic        signed_op;
  logic        sa;
  logic        sb;

  assign signed_op = (op == MULT) || (op == DIV);
  assign sa        = signed_op & rs_dat[31];
  assign sb        = signed_op & rt_dat[31];

  // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient};
  // one shared 33-bit adder/subtractor serves both iterations.
  always_comb begin
    opa   = is_div_q ? {acc_q[63:32], acc_q[31]} : {1'b0, acc_q[63:32]};
    opb   = (is_div_q || acc_q[0]) ? {1'b0, b_q} : 33'd0;
    opb_x = is_div_q ? ~opb : opb;
    sum   = {1'b0, opa} + {1'b0, opb_x} + {33'd0, is_div_q};
    if (is_div_q) begin
      // Carry out set means no borrow: the trial subtraction is kept.
      acc_d = sum[33] ? {sum[31:0], acc_q[30:0], 1'b1}
                      : {opa[31:0], acc_q[30:0], 1'b0};
    end else begin
      acc_d = {sum[32:0], acc_q[31:1]};
    end
  end

  always_comb begin
    prod = neg_q ? (~acc_q + 64'd1) : acc_q;
    if (is_div_q) begin
      res_lo = div0_q ? 32'hFFFF_FFFF : mag(acc_q[31:0], neg_q);
      res_hi = mag(acc_q[63:32], neg_rem_q);
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= MD_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      b_q       <= 32'd0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= MD_IDLE;
      end else begin
        case (state_q)
          MD_IDLE: begin
            if (start) begin
              case (op)
                MULT, MULTU, DIV, DIVU: begin
                  acc_q     <= {32'd0, mag(rs_dat, sa)};
                  b_q       <= mag(rt_dat, sb);
                  is_div_q  <= (op == DIV) || (op == DIVU);
                  neg_q     <= sa ^ sb;
                  neg_rem_q <= sa;
                  div0_q    <= (rt_dat == 32'd0);
                  cnt_q     <= 5'd31;
                  state_q   <= MD_RUN;
                end
                MTHI:    hi_q <= rs_dat;
                MTLO:    lo_q <= rs_dat;
                default: ;
              endcase
            end
          end
          MD_RUN: begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - 5'd1;
            if (cnt_q == 5'd0) state_q <= MD_FIX;
          end
          MD_FIX: begin
            hi_q    <= res_hi;
            lo_q    <= res_lo;
            done_q  <= 1'b1;
            state_q <= MD_IDLE;
          end
          default: state_q <= MD_IDLE;
        endcase
      end
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
  import cpu_types_pkg::*;

  logic       CLK;
  logic       nRST;
  logic       start;
  muldiv_op_t op;
  word_t      rs_dat;
  word_t      rt_dat;
  logic       flush;
  logic       busy;
  logic       done;
  word_t      hi;
  word_t      lo;

  int checks;
  int errors;
  int dcyc;
  int bcnt;
  int seen;

  muldiv_unit dut (
    .CLK    (CLK),
    .nRST   (nRST),
    .start  (start),
    .op     (op),
    .rs_dat (rs_dat),
    .rt_dat (rt_dat),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .hi     (hi),
    .lo     (lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive start at a negedge; returns just after the start edge.
  task automatic issue(input muldiv_op_t o, input word_t a, input word_t b);
    @(negedge CLK);
    start  = 1'b1;
    op     = o;
    rs_dat = a;
    rt_dat = b;
    @(posedge CLK);
  endtask

  // Counts negedges after the start edge until done; scrambles operands and
  // optionally re-pulses start mid-RUN with a different op.
  task automatic wait_done(input bit perturb, output int dc, output int bc);
    dc = -1;
    bc = 0;
    for (int j = 1; j <= 60; j++) begin
      @(negedge CLK);
      if (j == 1) begin
        start  = 1'b0;
        rs_dat = 32'h5A5A_1234;
        rt_dat = 32'h0000_0003;
      end
      if (perturb && j == 5) begin
        start  = 1'b1;
        op     = DIVU;
        rs_dat = 32'h0000_0011;
        rt_dat = 32'h0000_0002;
      end
      if (perturb && j == 6) start = 1'b0;
      if (busy) bc++;
      if (done) begin
        dc = j;
        break;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nRST   = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    op     = MULT;
    rs_dat = 32'd0;
    rt_dat = 32'd0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_hi", {32'd0, hi}, 64'd0);
    chk("rst_lo", {32'd0, lo}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;

    issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1'b0, dcyc, bcnt);
    chk("multu_latency", 64'(dcyc), 64'd34);
    chk("multu_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", {32'd0, lo}, 64'h0000_0000_0000_0001);

    issue(MULT, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done(1'b1, dcyc, bcnt);
    chk("mult_latency", 64'(dcyc), 64'd34);
    chk("mult_busy_cycles", 64'(bcnt), 64'd33);
    chk("mult_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);

    issue(DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(1'b0, dcyc, bcnt);
    chk("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    chk("div_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);

    issue(DIVU, 32'd100, 32'd0);
    wait_done(1'b0, dcyc, bcnt);
    chk("divu0_latency", 64'(dcyc), 64'd34);
    chk("divu0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    chk("divu0_hi", {32'd0, hi}, 64'h0000_0000_0000_0064);

    issue(DIV, 32'hFFFF_FFF0, 32'd0);
    wait_done(1'b0, dcyc, bcnt);
    chk("div0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    chk("div0_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFF0);

    issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1'b0, dcyc, bcnt);
    chk("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    chk("div_ovf_hi", {32'd0, hi}, 64'd0);
    start  = 1'b1;
    op     = MTHI;
    rs_dat = 32'h1234_5678;
    @(negedge CLK);
    start = 1'b0;
    chk("mthi_b2b_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    chk("mthi_b2b_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    chk("mthi_no_done", {62'd0, done, busy}, 64'd0);

    issue(MTLO, 32'hCAFE_F00D, 32'd0);
    @(negedge CLK);
    start = 1'b0;
    chk("mtlo_lo", {32'd0, lo}, 64'h0000_0000_CAFE_F00D);
    chk("mtlo_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);

    @(negedge CLK);
    start  = 1'b1;
    flush  = 1'b1;
    op     = MTHI;
    rs_dat = 32'hDEAD_BEEF;
    @(negedge CLK);
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);

    issue(MULT, 32'd5, 32'd6);
    seen = 0;
    for (int j = 1; j <= 50; j++) begin
      @(negedge CLK);
      if (j == 1) start = 1'b0;
      if (j == 10) flush = 1'b1;
      if (j == 11) begin
        flush = 1'b0;
        chk("flush_busy", {63'd0, busy}, 64'd0);
      end
      if (done) seen++;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    chk("flush_hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    chk("flush_lo", {32'd0, lo}, 64'h0000_0000_CAFE_F00D);

    issue(MULT, 32'd5, 32'd6);
    seen = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge CLK);
      if (j == 1) start = 1'b0;
      if (done) seen++;
    end
    nRST = 1'b0;
    #1;
    chk("rst_mid_hi", {32'd0, hi}, 64'd0);
    chk("rst_mid_lo", {32'd0, lo}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    for (int j = 1; j <= 50; j++) begin
      @(negedge CLK);
      if (done) seen++;
    end
    chk("rst_no_done", 64'(seen), 64'd0);
    chk("rst_after_hilo", {hi, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameters: none; word width SHALL be word_t (32 bits) from cpu_types_pkg.
REQ-002 CLK  in  1  single clock; all state SHALL update on rising edge only.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 start  in  1  request to begin/perform op; sampled only when busy=0.
REQ-005 op  in  3  muldiv_op_t: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
REQ-006 rs_dat  in  32  operand A / dividend / MTHI-MTLO source; driven from register file rdat1.
REQ-007 rt_dat  in  32  operand B / divisor; driven from register file rdat2.
REQ-008 flush  in  1  pipeline kill of any in-flight op.
REQ-009 busy  out  1  high while an iterative op is in flight; decode stalls MFHI/MFLO/new muldiv on it.
REQ-010 done  out  1  one-cycle pulse when HI/LO hold a new iterative result.
REQ-011 hi, lo  out  32 each  architectural HI/LO; MFHI/MFLO feed them to the register file write port.

Function
REQ-012 States: IDLE, RUN, FIX; busy SHALL equal (state != IDLE), combinational from state.
REQ-013 IDLE + start + op in {MULT,MULTU,DIV,DIVU}: capture operand magnitudes and signs, load 5-bit counter to 31, go to RUN.
REQ-014 IDLE + start + MTHI (MTLO): hi (lo) SHALL take rs_dat at that edge; no busy, no done; other register unchanged.
REQ-015 RUN: one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle; counter decrements; counter==0 moves to FIX; exactly 32 RUN cycles.
REQ-016 FIX: apply sign correction, write hi/lo, pulse done, return to IDLE; new hi/lo and done=1 SHALL be visible in the cycle 34 edges after the start edge (start edge, 32 RUN, 1 FIX edge).
REQ-017 MULT/MULTU: {hi,lo} = full 64-bit signed/unsigned product.
REQ-018 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-019 Divisor 0: same latency; lo = 0xFFFFFFFF, hi = dividend (rs_dat), for both DIV and DIVU.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0x00000000; no trap.
REQ-021 start while busy=1 SHALL be ignored; operands and op SHALL not be re-sampled.
REQ-022 flush in any state: next state IDLE, hi/lo unchanged, no done; flush and start in same IDLE cycle: flush wins, nothing happens.
REQ-023 Operand changes on rs_dat/rt_dat after the start edge SHALL not affect the result.
REQ-024 The done-cycle IDLE SHALL accept a new start (back-to-back issue, no bubble).

Reset
REQ-025 nRST low: state=IDLE, counter=0, hi=0, lo=0, done=0, busy=0, internal datapath registers 0, immediately and regardless of CLK.
REQ-026 Reset mid-operation SHALL abandon the op; no done after reset release.

Structure
REQ-027 muldiv_op_t enum SHALL be added to cpu_types_pkg; word_t reused from it.
REQ-028 No sub-module: control FSM and 64-bit shared shift datapath stay in muldiv_unit.
REQ-029 A single 33-bit adder/subtractor SHALL be shared between multiply and divide iterations.

Verification
REQ-030 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done 34 edges after start; hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT 0xFFFFFFFD (-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 33 cycles.
REQ-032 DIV 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=0x00000064.
REQ-033 DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; then MTHI 0x12345678 in done cycle -> hi=0x12345678, lo unchanged.
REQ-034 MULT issued, flush at RUN cycle 10 -> busy low next cycle, no done, hi/lo keep prior values; repeat with nRST low at cycle 10 -> hi=lo=0, no done.
REQ-035 start pulsed again during RUN with different operands -> ignored; original result delivered on schedule.
